fwd_hazard_ctrl: RTL

Forwarding and hazard controller for the 5-stage pipelined core. It shadows the destination/control fields of the ID/EX, EX/MEM and MEM/WB stages internally. From that state it drives the 2-bit selects of the two EX-stage operand forwarding mux3 instances, plus stall, bubble and flush controls to the pipeline registers. It also sequences multi-cycle EX operations (multiply class) through a small FSM with a latency counter.

---
 rtl/fwd_hazard_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control for the 5-stage core: shadows ID/EX, EX/MEM, MEM/WB
// destination fields and sequences multi-cycle EX ops through a RUN/MC_WAIT FSM.
module fwd_hazard_ctrl #(
  parameter int REG_W  = 5,
  parameter int MC_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_mc,
  input  logic             ex_branch_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             id_ex_bubble,
  output logic             flush_if_id,
  output logic             ex_hold,
  output logic             mc_busy
);

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             use_rs1;
    logic             use_rs2;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
    logic             mc;
  } idex_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } exmem_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
  } memwb_t;

  typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MC_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt, cnt_dec;
  idex_t      idex, id_entry;
  exmem_t     exmem;
  memwb_t     memwb;
  logic       mc_start, load_use;

  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_W-1:0] src,
                                         input exmem_t em, input memwb_t mw);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src) begin
      if (em.regwrite && em.rd != '0 && em.rd == src)
        sel = 2'b10;
      else if (mw.regwrite && mw.rd != '0 && mw.rd == src)
        sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    id_entry = '0;
    if (id_valid) begin
      id_entry.rs1      = id_rs1;
      id_entry.rs2      = id_rs2;
      id_entry.use_rs1  = id_use_rs1;
      id_entry.use_rs2  = id_use_rs2;
      id_entry.rd       = id_rd;
      id_entry.regwrite = id_regwrite;
      id_entry.memread  = id_memread;
      id_entry.mc       = id_mc;
    end
  end

  // A nonzero counter in RUN marks the mc op in ID/EX as already served.
  assign mc_start = (state == RUN) && idex.mc && (MC_LAT > 1) && (cnt == 4'd0);
  assign cnt_dec  = cnt - 4'd1;

  // State register and pipeline shadows
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      memwb <= '{rd: exmem.rd, regwrite: exmem.regwrite};
      if (ex_hold)
        exmem <= '0;
      else
        exmem <= '{rd: idex.rd, regwrite: idex.regwrite, memread: idex.memread};
      if (!ex_hold) begin
        if (id_ex_bubble)
          idex <= '0;
        else
          idex <= id_entry;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (mc_start) begin
          cnt_nxt   = LAT_M1;
          state_nxt = (MC_LAT > 2) ? MC_WAIT : RUN;
        end else if (cnt != 4'd0) begin
          cnt_nxt = '0;
        end
      end
      MC_WAIT: begin
        cnt_nxt = cnt_dec;
        if (cnt_dec == 4'd1)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    mc_busy      = (state == MC_WAIT);
    ex_hold      = mc_start || (state == MC_WAIT);
    load_use     = (state == RUN) && !ex_hold && idex.memread && (idex.rd != '0) && id_valid &&
                   ((id_use_rs1 && id_rs1 == idex.rd) || (id_use_rs2 && id_rs2 == idex.rd));
    flush_if_id  = ex_branch_taken && (state == RUN) && !ex_hold;
    id_ex_bubble = load_use || flush_if_id;
    stall        = ex_hold || (load_use && !flush_if_id);
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    if (state == RUN) begin
      fwd_a = fwd_sel(idex.use_rs1, idex.rs1, exmem, memwb);
      fwd_b = fwd_sel(idex.use_rs2, idex.rs2, exmem, memwb);
    end
  end

endmodule
